// File: rtl/processor_accum_param.sv
// processor_accum_param: parametrised multi-cycle accumulator processor.
// Each instruction takes FETCH -> DECODE -> EXEC; HLT parks the core in
// HALT until reset. Instruction memory is external and read combinationally
// at instr_addr. The register file can be preloaded from outside via rf_we.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   instr_addr   fetch address (equals pc)
//   instr_data   16-bit instruction word, sampled in FETCH
//   rf_we        external register-file write enable
//   rf_waddr     external write index
//   rf_wdata     external write data
//   ACC, z, cy   accumulator, zero flag, carry/borrow flag
//   pc           program counter
//   state        FETCH=0, DECODE=1, EXEC=2, HALT=3
//   halted       high while in HALT
//
// state  | meaning
// -------+--------------------------------------------------
// FETCH  | latch instruction word, advance pc
// DECODE | read selected register into operand B
// EXEC   | execute opcode, update ACC/flags/pc/register
// HALT   | frozen; only reset leaves (preload still allowed)

module processor_accum_param #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    parameter int PC_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [PC_W-1:0]          instr_addr,
    input  logic [15:0]              instr_data,
    input  logic                     rf_we,
    input  logic [$clog2(NREGS)-1:0] rf_waddr,
    input  logic [DATA_W-1:0]        rf_wdata,
    output logic [DATA_W-1:0]        ACC,
    output logic                     z,
    output logic                     cy,
    output logic [PC_W-1:0]          pc,
    output logic [1:0]               state,
    output logic                     halted
);

    localparam int RI_W  = $clog2(NREGS);
    localparam int IMM_N = (DATA_W < 8) ? DATA_W : 8;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                z_q, z_d;
    logic                cy_q, cy_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];

    logic [3:0]          op;
    logic [RI_W-1:0]     rsel;
    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   rd_val;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   diff;
    logic                borrow;
    logic [DATA_W-1:0]   res;
    logic                upd_z;
    logic                wr_int;
    logic                unused_ir;

    assign op        = ir_q[15:12];
    assign rsel      = ir_q[8 +: RI_W];
    assign unused_ir = ^ir_q;

    always_comb begin
        imm_ext = '0;
        imm_ext[IMM_N-1:0] = ir_q[IMM_N-1:0];
    end

    always_comb begin
        rd_val = '0;
        if (int'(rsel) < NREGS) rd_val = regs_q[rsel];
    end

    // ADC folds the held carry into the same adder as ADD.
    assign sum    = {1'b0, acc_q} + {1'b0, b_q}
                  + {{DATA_W{1'b0}}, (op == 4'h8) & cy_q};
    assign diff   = acc_q - b_q;
    assign borrow = (acc_q < b_q);
    assign wr_int = (state_q == S_EXEC) && (op == 4'h2);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        z_d     = z_q;
        cy_d    = cy_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        regs_d  = regs_q;
        res     = '0;
        upd_z   = 1'b0;

        // An internal MOV R,A wins the write port outright; any external
        // write in that cycle is discarded rather than deferred.
        if (wr_int) begin
            if (int'(rsel) < NREGS) regs_d[rsel] = acc_q;
        end else if (rf_we && (int'(rf_waddr) < NREGS)) begin
            regs_d[rf_waddr] = rf_wdata;
        end

        case (state_q)
            S_FETCH: begin
                ir_d    = instr_data;
                pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                state_d = S_DECODE;
            end
            S_DECODE: begin
                b_d     = rd_val;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    4'h1: acc_d = b_q;
                    4'h3, 4'h8: begin
                        res   = sum[DATA_W-1:0];
                        acc_d = res;
                        cy_d  = sum[DATA_W];
                        upd_z = 1'b1;
                    end
                    4'h4: begin
                        res   = diff;
                        acc_d = res;
                        cy_d  = borrow;
                        upd_z = 1'b1;
                    end
                    4'h5, 4'h6, 4'h7: begin
                        res   = (op == 4'h5) ? (acc_q & b_q) :
                                (op == 4'h6) ? (acc_q | b_q) : (acc_q ^ b_q);
                        acc_d = res;
                        cy_d  = 1'b0;
                        upd_z = 1'b1;
                    end
                    4'h9: acc_d = imm_ext;
                    // Jumps see the flags as they stood before this EXEC.
                    4'hA: if (z_q)  pc_d = ir_q[PC_W-1:0];
                    4'hB: if (cy_q) pc_d = ir_q[PC_W-1:0];
                    4'hC: pc_d = ir_q[PC_W-1:0];
                    4'hD: begin
                        res   = acc_q + {{(DATA_W-1){1'b0}}, 1'b1};
                        acc_d = res;
                        upd_z = 1'b1;
                    end
                    4'hE: begin
                        res   = diff;
                        cy_d  = borrow;
                        upd_z = 1'b1;
                    end
                    4'hF: state_d = S_HALT;
                    default: ;
                endcase
                if (upd_z) z_d = (res == '0);
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            acc_q   <= '0;
            b_q     <= '0;
            z_q     <= 1'b0;
            cy_q    <= 1'b0;
            pc_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            z_q     <= z_d;
            cy_q    <= cy_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign instr_addr = pc_q;
    assign pc         = pc_q;
    assign ACC        = acc_q;
    assign z          = z_q;
    assign cy         = cy_q;
    assign state      = state_q;
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_processor_accum_param.sv
// Bench for processor_accum_param: default-width core plus a PC_W=4 core
// for wrap-around. Expected values are queued when a program is set up and
// popped in order at fixed cycle points after reset release.
module tb_processor_accum_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  instr_addr;
    logic [15:0] instr_data;
    logic        rf_we = 1'b0;
    logic [2:0]  rf_waddr = '0;
    logic [7:0]  rf_wdata = '0;
    logic [7:0]  acc;
    logic        z, cy, halted;
    logic [7:0]  pc;
    logic [1:0]  state;

    logic [3:0]  instr_addr4, pc4;
    logic [15:0] instr_data4;
    logic [7:0]  acc4;
    logic        z4, cy4, halted4;
    logic [1:0]  state4;

    logic [15:0] imem  [256];
    logic [15:0] imem4 [16];

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;
    sb_item_t sb_q[$];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    assign instr_data  = imem[instr_addr];
    assign instr_data4 = imem4[instr_addr4];

    processor_accum_param u_dut (
        .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr_data(instr_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ACC(acc), .z(z), .cy(cy), .pc(pc), .state(state), .halted(halted)
    );

    processor_accum_param #(.DATA_W(8), .NREGS(8), .PC_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .instr_addr(instr_addr4), .instr_data(instr_data4),
        .rf_we(1'b0), .rf_waddr(3'd0), .rf_wdata(8'd0),
        .ACC(acc4), .z(z4), .cy(cy4), .pc(pc4), .state(state4), .halted(halted4)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", obs, 32'hDEAD_BEEF);
        end else begin
            it = sb_q.pop_front();
            check_val(it.tag, obs, it.exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] r, input logic [7:0] imm);
        return {op, r, imm};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic rf_write(input logic [2:0] a, input logic [7:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        tick(1);
        rf_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) imem4[i] = 16'h0000;
        imem4[0] = ins(4'hC, 4'h0, 8'h0F);
        clear_mem();
        tick(2);

        // Reset in the middle of an ADD's EXEC with ACC=5.
        imem[0] = ins(4'h9, 4'h0, 8'h05);
        imem[1] = ins(4'h3, 4'h0, 8'h00);
        sb_push("t1_pre_acc", 5);
        sb_push("t1_pre_state", 2);
        sb_push("t1_rst_acc", 0);
        sb_push("t1_rst_pc", 0);
        sb_push("t1_rst_state", 0);
        sb_push("t1_rst_z", 0);
        sb_push("t1_rst_cy", 0);
        sb_push("t1_mvi_acc", 8'h77);
        sb_push("t1_r0_cleared", 0);
        do_reset();
        rf_write(3'd0, 8'h02);
        tick(4);
        sb_check(acc);
        sb_check(state);
        clear_mem();
        imem[0] = ins(4'h9, 4'h0, 8'h77);
        imem[1] = ins(4'h1, 4'h0, 8'h00);
        reset = 1'b1;
        tick(1);
        sb_check(acc);
        sb_check(pc);
        sb_check(state);
        sb_check(z);
        sb_check(cy);
        reset = 1'b0;
        tick(3);
        sb_check(acc);
        tick(3);
        sb_check(acc);

        // Sum of preloaded R0..R5; three NOPs cover the preload cycles,
        // so the summing program starts at address 3.
        clear_mem();
        for (int i = 0; i < 3; i++) imem[i] = 16'h0000;
        imem[3] = ins(4'h1, 4'h0, 8'h00);
        for (int i = 1; i <= 5; i++) imem[3+i] = ins(4'h3, 4'(i), 8'h00);
        imem[9] = ins(4'hF, 4'h0, 8'h00);
        sb_push("t2_not_halted_e29", 0);
        sb_push("t2_halted_e30", 1);
        sb_push("t2_acc", 8'h15);
        sb_push("t2_z", 0);
        sb_push("t2_cy", 0);
        sb_push("t2_pc_halt", 10);
        sb_push("t2_pc_frozen", 10);
        sb_push("t2_acc_frozen", 8'h15);
        do_reset();
        for (int i = 0; i < 6; i++) rf_write(3'(i), 8'(i + 1));
        tick(23);
        sb_check(halted);
        tick(1);
        sb_check(halted);
        sb_check(acc);
        sb_check(z);
        sb_check(cy);
        sb_check(pc);
        tick(5);
        sb_check(pc);
        sb_check(acc);

        // Carry, ADC, CMP borrow, JC taken, JZ not taken.
        clear_mem();
        imem[0] = 16'h0000;
        imem[1] = 16'h0000;
        imem[2] = ins(4'h9, 4'h0, 8'hFF);
        imem[3] = ins(4'h3, 4'h0, 8'h00);
        imem[4] = ins(4'h8, 4'h0, 8'h00);
        imem[5] = ins(4'h9, 4'h0, 8'h03);
        imem[6] = ins(4'hE, 4'h1, 8'h00);
        imem[7] = ins(4'hB, 4'h0, 8'h20);
        imem[8'h20] = ins(4'hA, 4'h0, 8'h30);
        imem[8'h21] = ins(4'hF, 4'h0, 8'h00);
        sb_push("t3_add_acc", 0);
        sb_push("t3_add_z", 1);
        sb_push("t3_add_cy", 1);
        sb_push("t3_adc_acc", 2);
        sb_push("t3_adc_z", 0);
        sb_push("t3_adc_cy", 0);
        sb_push("t3_cmp_acc", 3);
        sb_push("t3_cmp_cy", 1);
        sb_push("t3_cmp_z", 0);
        sb_push("t3_jc_pc", 8'h20);
        sb_push("t3_jz_fall_pc", 8'h21);
        sb_push("t3_halted", 1);
        do_reset();
        rf_write(3'd0, 8'h01);
        rf_write(3'd1, 8'h05);
        tick(10);
        sb_check(acc);
        sb_check(z);
        sb_check(cy);
        tick(3);
        sb_check(acc);
        sb_check(z);
        sb_check(cy);
        tick(6);
        sb_check(acc);
        sb_check(cy);
        sb_check(z);
        tick(3);
        sb_check(pc);
        tick(3);
        sb_check(pc);
        tick(3);
        sb_check(halted);

        // Internal MOV R2,A collides with an external write to R2;
        // then an external write to R3 lands while halted.
        clear_mem();
        imem[0] = ins(4'h9, 4'h0, 8'h09);
        imem[1] = ins(4'h2, 4'h2, 8'h00);
        imem[2] = ins(4'h9, 4'h0, 8'h00);
        imem[3] = ins(4'h1, 4'h2, 8'h00);
        imem[4] = ins(4'hF, 4'h0, 8'h00);
        sb_push("t4_r2_internal_wins", 9);
        sb_push("t4_halted", 1);
        sb_push("t4_pc_halt", 5);
        sb_push("t4_r3_halt_write", 8'h5A);
        sb_push("t4_still_halted", 1);
        do_reset();
        tick(5);
        rf_write(3'd2, 8'h44);
        tick(6);
        sb_check(acc);
        tick(3);
        sb_check(halted);
        sb_check(pc);
        rf_write(3'd3, 8'h5A);
        sb_check(u_dut.regs_q[3]);
        sb_check(halted);

        // PC_W=4 core: JMP 0xF, NOP at 0xF wraps pc to 0, refetch from 0.
        sb_push("t5_jmp_pc", 4'hF);
        sb_push("t5_wrap_pc", 4'h0);
        sb_push("t5_fetch_addr0", 4'h0);
        sb_push("t5_refetch_jmp_pc", 4'hF);
        do_reset();
        tick(3);
        sb_check(pc4);
        tick(1);
        sb_check(pc4);
        tick(2);
        sb_check(instr_addr4);
        tick(3);
        sb_check(pc4);

        check_val("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
